// File: rtl/vit_conv0_dma_rd_axi_pkg.sv
// ---------------------------------------------------------------------------
// vit_conv0_dma_rd_axi_pkg
// Shared constants and helpers for the conv0 data-DMA AXI read front end.
//   - Command payload layout {len_minus1, base_addr, offset}. These values
//     match the burst-length and field-offset defines shared across the CNN
//     codebase.
//   - AR-path FSM state encodings.
//   - Helpers that decode a command payload into an AR beat.
// ---------------------------------------------------------------------------
package vit_conv0_dma_rd_axi_pkg;

  localparam int LOG2_AXI_BURST_LEN = 4;
  localparam int LEN_LSB            = 64;
  localparam int BASE_LSB           = 32;
  localparam int OFS_LSB            = 0;
  localparam int PD_W               = LOG2_AXI_BURST_LEN + 64;

  // The two AR-path states, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_AR_PEND = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_cmd_t;

  // The burst start address is base + offset. Any carry out of bit 31 is
  // discarded, so the address wraps within the 4 GiB space.
  function automatic logic [31:0] pd_addr(input logic [PD_W-1:0] pd);
    return pd[BASE_LSB +: 32] + pd[OFS_LSB +: 32];
  endfunction

  function automatic logic [7:0] pd_arlen(input logic [PD_W-1:0] pd);
    return 8'(pd[LEN_LSB +: LOG2_AXI_BURST_LEN]);
  endfunction

endpackage

// File: rtl/vit_dma_len_fifo.sv
// ---------------------------------------------------------------------------
// vit_dma_len_fifo
// A small FIFO that holds the arlen of each issued burst, so the R-side
// rlast checker can compare against it. The head entry is available
// combinationally on dout.
// This block exists only when VIT_DMA_RLAST_CHK_EN is defined.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    write one 8-bit entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   dout         head entry
//   empty, full  occupancy flags
// ---------------------------------------------------------------------------
`ifdef VIT_DMA_RLAST_CHK_EN
module vit_dma_len_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // The pointers carry one extra wrap bit. That bit lets the logic tell full
  // from empty when the index bits are equal.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array has no reset. Only the pointers define validity,
  // so resetting the storage would add reset fan-out and gain nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  // NOTE: state registers use non-blocking assignments only. This way every
  // flop samples values from before the edge, whatever order the
  // assignments are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule
`endif

// File: rtl/vit_conv0_dma_rd_axi.sv
// ---------------------------------------------------------------------------
// vit_conv0_dma_rd_axi
// The AXI read front end of the conv0 feature-data DMA.
// It turns rd_req commands into AR bursts, throttles the number of
// outstanding bursts to OUTST_MAX, and passes R data straight through to the
// feature buffer.
// Optional macro VIT_DMA_RLAST_CHK_EN adds a sticky err output. err flags any
// rlast that disagrees with the arlen of its burst.
// Ports:
//   rd_req_vld/rdy/pd    command in: {len_minus1, base_addr, offset}
//   arvalid/arready      AR handshake
//   araddr, arlen        AR payload
//   rvalid/rready        R handshake
//   rdata, rlast         R payload
//   dat_vld/rdy/pd       data out to the feature buffer (combinational)
//   idle                 no AR pending and no burst outstanding
//   err_clr, err         synchronous clear; sticky rlast error (macro only)
// ---------------------------------------------------------------------------
module vit_conv0_dma_rd_axi
  import vit_conv0_dma_rd_axi_pkg::*;
#(
  parameter int AXI_DW    = 128,
  parameter int OUTST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [PD_W-1:0]   rd_req_pd,
  output logic              arvalid,
  input  logic              arready,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [AXI_DW-1:0] rdata,
  input  logic              rlast,
  output logic              dat_vld,
  input  logic              dat_rdy,
  output logic [AXI_DW-1:0] dat_pd,
  output logic              idle,
  input  logic              err_clr
`ifdef VIT_DMA_RLAST_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int CW = $clog2(OUTST_MAX) + 1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [CW-1:0] outst_cnt_q, outst_cnt_d;
  logic [CW:0]   inflight;
  logic          ar_pending, req_hs, ar_hs, r_hs, rlast_hs;

  assign ar_pending = (state_q == ST_AR_PEND);
  assign arvalid    = ar_pending;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;

  // The AR that is still pending counts against the limit. In AR_PEND, a
  // new command is accepted only in the cycle the pending AR hands off.
  // That allows back-to-back bursts at one per cycle.
  assign inflight   = {1'b0, outst_cnt_q} + (CW+1)'(ar_pending);
  assign rd_req_rdy = (!ar_pending || arready) &&
                      (inflight < (CW+1)'(OUTST_MAX));

  assign req_hs   = rd_req_vld && rd_req_rdy;
  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && dat_rdy;
  assign rlast_hs = r_hs && rlast;

  // The R channel is a pure wire. It has no buffering and no dependency on
  // reset state, so any stale beats after a reset still drain.
  assign dat_vld = rvalid;
  assign rready  = dat_rdy;
  assign dat_pd  = rdata;

  assign idle = !ar_pending && (outst_cnt_q == '0);

  // NOTE: every combinational output gets a default before any branch, so
  // no path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    if (ar_hs) state_d = ST_IDLE;
    if (req_hs) begin
      state_d  = ST_AR_PEND;
      araddr_d = pd_addr(rd_req_pd);
      arlen_d  = pd_arlen(rd_req_pd);
    end
  end

  // An AR and an rlast in the same cycle cancel out. After a reset, a stale
  // rlast finds the count at zero and must not take it below zero.
  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (ar_hs && !rlast_hs)
      outst_cnt_d = outst_cnt_q + CW'(1);
    else if (rlast_hs && !ar_hs && (outst_cnt_q != '0))
      outst_cnt_d = outst_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      araddr_q    <= '0;
      arlen_q     <= '0;
      outst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end

`ifdef VIT_DMA_RLAST_CHK_EN
  logic [7:0] exp_len, beat_cnt_q, beat_cnt_d;
  logic       len_fifo_empty, len_fifo_full_unused;
  logic       mismatch, err_q, err_d;

  vit_dma_len_fifo #(
    .DEPTH (OUTST_MAX)
  ) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .din   (arlen_q),
    .pop   (rlast_hs),
    .dout  (exp_len),
    .empty (len_fifo_empty),
    .full  (len_fifo_full_unused)
  );

  // beat_cnt_q is the zero-based index of the current beat. When the FIFO is
  // empty, no burst is on record (for example, stale beats after a reset),
  // so there is nothing to check against.
  assign mismatch = r_hs && !len_fifo_empty &&
                    ((rlast && (beat_cnt_q != exp_len)) ||
                     (!rlast && (beat_cnt_q == exp_len)));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (rlast_hs)  beat_cnt_d = '0;
    else if (r_hs) beat_cnt_d = beat_cnt_q + 8'd1;
    err_d = (err_q && !err_clr) || mismatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_vit_conv0_dma_rd_axi.sv
// ---------------------------------------------------------------------------
// tb_vit_conv0_dma_rd_axi
// Directed bench for vit_conv0_dma_rd_axi.
// Each accepted command pushes its expected AR beat into a queue. An
// independent monitor pops that queue on every AR handshake and compares.
// Inline checks cover reset values, the R pass-through, the outstanding
// count, idle and err.
// ---------------------------------------------------------------------------
module tb_vit_conv0_dma_rd_axi;
  import vit_conv0_dma_rd_axi_pkg::*;

  localparam int AXI_DW    = 128;
  localparam int OUTST_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_req_vld = 1'b0;
  logic              rd_req_rdy;
  logic [PD_W-1:0]   rd_req_pd = '0;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [AXI_DW-1:0] rdata = '0;
  logic              rlast = 1'b0;
  logic              dat_vld;
  logic              dat_rdy = 1'b0;
  logic [AXI_DW-1:0] dat_pd;
  logic              idle;
  logic              err_clr = 1'b0;
`ifdef VIT_DMA_RLAST_CHK_EN
  logic              err;
`endif

  int      vectors = 0;
  int      miscompares = 0;
  int      ar_count = 0;
  ar_cmd_t exp_q[$];

  always #5 clk = ~clk;

  vit_conv0_dma_rd_axi #(
    .AXI_DW    (AXI_DW),
    .OUTST_MAX (OUTST_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req_vld (rd_req_vld),
    .rd_req_rdy (rd_req_rdy),
    .rd_req_pd  (rd_req_pd),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rlast      (rlast),
    .dat_vld    (dat_vld),
    .dat_rdy    (dat_rdy),
    .dat_pd     (dat_pd),
    .idle       (idle),
    .err_clr    (err_clr)
`ifdef VIT_DMA_RLAST_CHK_EN
    ,
    .err        (err)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor. Inputs change just after the rising edge, so the
  // falling edge sees the values the next rising edge will capture.
  always @(negedge clk) begin
    if (rst_n && arvalid && arready) begin
      ar_cmd_t e;
      ar_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ar_unexpected: araddr 0x%0h arlen %0d with empty queue", araddr, arlen);
      end else begin
        e = exp_q.pop_front();
        check("ar_addr", 128'(araddr), 128'(e.addr));
        check("ar_len", 128'(arlen), 128'(e.len));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and waits (bounded) until it is accepted. The
  // expected AR is queued as soon as the accept condition is seen.
  task automatic send_req(input logic [3:0] len, input logic [31:0] base, input logic [31:0] ofs);
    int      budget;
    ar_cmd_t e;
    budget     = 50;
    rd_req_vld = 1'b1;
    rd_req_pd  = {len, base, ofs};
    #1;
    while (!rd_req_rdy && budget > 0) begin
      tick();
      #1;
      budget--;
    end
    if (!rd_req_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept_timeout: base 0x%0h not accepted", base);
    end else begin
      e.addr = base + ofs;
      e.len  = 8'(len);
      exp_q.push_back(e);
    end
    tick();
    rd_req_vld = 1'b0;
  endtask

  // One R beat with dat_rdy high. The pass-through is checked on the way.
  task automatic beat(input logic last);
    rvalid  = 1'b1;
    rlast   = last;
    dat_rdy = 1'b1;
    rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    check("beat_dat_vld", 128'(dat_vld), 128'(1));
    check("beat_dat_pd", dat_pd, rdata);
    tick();
    rvalid  = 1'b0;
    rlast   = 1'b0;
    dat_rdy = 1'b0;
  endtask

  initial begin
    int          n;
    int          ar0;
    logic [127:0] pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", 128'(arvalid), 128'(0));
    check("rst_araddr", 128'(araddr), 128'(0));
    check("rst_arlen", 128'(arlen), 128'(0));
    check("rst_idle", 128'(idle), 128'(1));
    check("rst_outst", 128'(dut.outst_cnt_q), 128'(0));
`ifdef VIT_DMA_RLAST_CHK_EN
    check("rst_err", 128'(err), 128'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Address add, one-cycle arvalid
    arready = 1'b1;
    send_req(4'd15, 32'h1000_0000, 32'h0000_0200);
    #1;
    check("add_arvalid", 128'(arvalid), 128'(1));
    check("add_araddr", 128'(araddr), 128'(32'h1000_0200));
    check("add_arlen", 128'(arlen), 128'(15));
    check("add_idle_busy", 128'(idle), 128'(0));
    tick();
    #1;
    check("add_arvalid_drop", 128'(arvalid), 128'(0));
    check("add_outst1", 128'(dut.outst_cnt_q), 128'(1));
    beat(1'b1);
    #1;
    check("add_idle_back", 128'(idle), 128'(1));

    // Address wrap and a single-beat burst
    send_req(4'd0, 32'hFFFF_FF00, 32'h0000_0200);
    #1;
    check("wrap_araddr", 128'(araddr), 128'(32'h0000_0100));
    check("wrap_arlen0", 128'(arlen), 128'(0));
    tick();
    beat(1'b1);

    // AR backpressure: payload held stable, no new command accepted
    arready = 1'b0;
    send_req(4'd7, 32'h2000_0000, 32'h0000_0040);
    rd_req_vld = 1'b1;
    rd_req_pd  = {4'd3, 32'h3000_0000, 32'h0000_0080};
    repeat (5) begin
      #1;
      check("bp_arvalid", 128'(arvalid), 128'(1));
      check("bp_araddr", 128'(araddr), 128'(32'h2000_0040));
      check("bp_arlen", 128'(arlen), 128'(7));
      check("bp_req_rdy", 128'(rd_req_rdy), 128'(0));
      tick();
    end
    rd_req_vld = 1'b0;
    arready    = 1'b1;
    // Accepted in the same cycle as the pending AR hands off
    send_req(4'd3, 32'h3000_0000, 32'h0000_0080);
    tick();
    #1;
    check("bp_outst2", 128'(dut.outst_cnt_q), 128'(2));
    // R backpressure: rready follows dat_rdy, the count does not move
    pat     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rdata   = pat;
    rvalid  = 1'b1;
    rlast   = 1'b1;
    dat_rdy = 1'b0;
    #1;
    check("rbp_rready", 128'(rready), 128'(0));
    check("rbp_dat_vld", 128'(dat_vld), 128'(1));
    check("rbp_dat_pd", dat_pd, pat);
    tick();
    check("rbp_outst", 128'(dut.outst_cnt_q), 128'(2));
    rvalid = 1'b0;
    #1;
    check("rbp_dat_vld_low", 128'(dat_vld), 128'(0));
    beat(1'b1);
    beat(1'b1);
    #1;
    check("bp_idle", 128'(idle), 128'(1));

    // AR and rlast handshakes in the same cycle at count 3
    send_req(4'd0, 32'h0000_1000, 32'h0);
    send_req(4'd0, 32'h0000_2000, 32'h0);
    send_req(4'd0, 32'h0000_3000, 32'h0);
    tick();
    arready = 1'b0;
    send_req(4'd0, 32'h0000_4000, 32'h0);
    #1;
    check("sim_outst_pre", 128'(dut.outst_cnt_q), 128'(3));
    arready = 1'b1;
    rvalid  = 1'b1;
    rlast   = 1'b1;
    dat_rdy = 1'b1;
    tick();
    rvalid  = 1'b0;
    rlast   = 1'b0;
    dat_rdy = 1'b0;
    #1;
    check("sim_outst_post", 128'(dut.outst_cnt_q), 128'(3));
    check("sim_arvalid", 128'(arvalid), 128'(0));
    repeat (3) beat(1'b1);
    #1;
    check("sim_idle", 128'(idle), 128'(1));

    // Throttle at OUTST_MAX outstanding
    ar0        = ar_count;
    n          = 0;
    rd_req_vld = 1'b1;
    rd_req_pd  = {4'd0, 32'h4000_0000, 32'(n * 64)};
    for (int i = 0; i < 25; i++) begin
      ar_cmd_t e;
      if (i == 20) begin
        rvalid  = 1'b1;
        rlast   = 1'b1;
        dat_rdy = 1'b1;
      end
      if (i == 20) check("thr_ar8", 128'(ar_count - ar0), 128'(8));
      if (i == 20) check("thr_outst8", 128'(dut.outst_cnt_q), 128'(OUTST_MAX));
      #1;
      if (i == 19) check("thr_rdy_low", 128'(rd_req_rdy), 128'(0));
      if (rd_req_rdy) begin
        e.addr = 32'h4000_0000 + 32'(n * 64);
        e.len  = 8'd0;
        exp_q.push_back(e);
        n++;
      end
      tick();
      rvalid    = 1'b0;
      rlast     = 1'b0;
      dat_rdy   = 1'b0;
      rd_req_pd = {4'd0, 32'h4000_0000, 32'(n * 64)};
    end
    #1;
    check("thr_ar9", 128'(ar_count - ar0), 128'(9));
    check("thr_rdy_low2", 128'(rd_req_rdy), 128'(0));
    rd_req_vld = 1'b0;
    repeat (OUTST_MAX) beat(1'b1);
    #1;
    check("thr_drained_idle", 128'(idle), 128'(1));
    check("thr_drained_outst", 128'(dut.outst_cnt_q), 128'(0));

    // Reset mid-burst, stale beats afterwards
    send_req(4'd1, 32'h0000_5000, 32'h0);
    send_req(4'd1, 32'h0000_6000, 32'h0);
    tick();
    arready = 1'b0;
    send_req(4'd1, 32'h0000_7000, 32'h0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_outst", 128'(dut.outst_cnt_q), 128'(0));
    check("mrst_arvalid", 128'(arvalid), 128'(0));
    check("mrst_araddr", 128'(araddr), 128'(0));
    check("mrst_idle", 128'(idle), 128'(1));
    tick();
    rst_n   = 1'b1;
    arready = 1'b1;
    tick();
    beat(1'b1);
    beat(1'b1);
    #1;
    check("stale_outst", 128'(dut.outst_cnt_q), 128'(0));
    check("stale_idle", 128'(idle), 128'(1));

`ifdef VIT_DMA_RLAST_CHK_EN
    // rlast checker
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("err_start", 128'(err), 128'(0));
    send_req(4'd3, 32'h5000_0000, 32'h0);
    tick();
    beat(1'b0);
    beat(1'b0);
    beat(1'b1);
    #1;
    check("err_early_rlast", 128'(err), 128'(1));
    repeat (3) tick();
    check("err_sticky", 128'(err), 128'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("err_cleared", 128'(err), 128'(0));
    send_req(4'd3, 32'h5000_0100, 32'h0);
    tick();
    repeat (3) beat(1'b0);
    beat(1'b1);
    #1;
    check("err_good_burst", 128'(err), 128'(0));
`endif

    repeat (2) tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
